// File: rtl/uart_rx_if.sv
// Bus between the UART receiver and its host logic: the baud load port, the
// serial pin and the received-byte outputs. The receiver uses the slave
// modport. o_Rx_Parity_Err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
    logic [31:0] CLKS_PER_BIT;
    logic        ld_CLKS_PER_BIT;
    logic        i_Rx_Serial;
    logic        o_Rx_DV;
    logic [7:0]  o_Rx_Byte;
    logic        o_Rx_Active;
    logic        o_Rx_Frame_Err;
`ifdef UART_RX_PARITY_EN
    logic        o_Rx_Parity_Err;
`endif

    modport master (
        output CLKS_PER_BIT, ld_CLKS_PER_BIT, i_Rx_Serial,
        input  o_Rx_DV, o_Rx_Byte, o_Rx_Active, o_Rx_Frame_Err
`ifdef UART_RX_PARITY_EN
        , input o_Rx_Parity_Err
`endif
    );

    modport slave (
        input  CLKS_PER_BIT, ld_CLKS_PER_BIT, i_Rx_Serial,
        output o_Rx_DV, o_Rx_Byte, o_Rx_Active, o_Rx_Frame_Err
`ifdef UART_RX_PARITY_EN
        , output o_Rx_Parity_Err
`endif
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a runtime-loadable clocks-per-bit value.
// Defining UART_RX_PARITY_EN adds an even-parity bit between the data and
// the stop bit, plus the o_Rx_Parity_Err pulse.
//
// state   | meaning
// IDLE    | line idle, waiting for a falling edge on the synchronised line
// START   | confirm the start bit at its midpoint
// DATA    | sample 8 data bits LSB-first at mid-bit
// PARITY  | sample the parity bit at mid-bit (UART_RX_PARITY_EN only)
// STOP    | sample the stop bit, publish the byte or flag an error
// CLEANUP | one-cycle gap before returning to IDLE
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic     i_Clock,
    input  logic     rst,
    uart_rx_if.slave io_Rx
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY  = 3'd3,
`endif
        S_STOP    = 3'd4,
        S_CLEANUP = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [31:0]            r_clks_per_bit;
    logic [31:0]            r_clk_count;
    logic [2:0]             r_bit_index;
    logic [7:0]             r_shadow;
    logic                   r_armed;
    logic                   w_rx_s;
    logic [31:0]            w_half;
    logic                   w_half_done;
    logic                   w_bit_done;
    logic                   w_baud_ok;
    logic                   w_stop_sample;
    logic                   w_parity_bad;
    logic                   w_dv_next;
    logic                   w_ferr_next;
    logic                   w_perr_next;
    logic                   w_active_next;
`ifdef UART_RX_PARITY_EN
    logic                   r_parity_bit;
`endif

    assign w_rx_s      = r_sync[SYNC_STAGES-1];
    assign w_half      = (r_clks_per_bit - 32'd1) >> 1;
    assign w_half_done = (r_clk_count == w_half);
    assign w_bit_done  = (r_clk_count == r_clks_per_bit - 32'd1);
    assign w_baud_ok   = (r_clks_per_bit >= 32'd2);

    // Synchronise the asynchronous serial pin; flops reset to the idle level.
    always_ff @(posedge i_Clock or posedge rst) begin
        if (rst) r_sync <= '1;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], io_Rx.i_Rx_Serial};
    end

    // State register.
    always_ff @(posedge i_Clock or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic. A start is only accepted once the line has been seen
    // high since the last frame error, so a held-low line reports one error.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_baud_ok && !w_rx_s) w_state_next = S_START;
            S_START:   if (w_half_done)
                           w_state_next = (!w_rx_s && r_armed) ? S_DATA : S_IDLE;
`ifdef UART_RX_PARITY_EN
            S_DATA:    if (w_bit_done && r_bit_index == 3'd7) w_state_next = S_PARITY;
            S_PARITY:  if (w_bit_done) w_state_next = S_STOP;
`else
            S_DATA:    if (w_bit_done && r_bit_index == 3'd7) w_state_next = S_STOP;
`endif
            S_STOP:    if (w_bit_done) w_state_next = S_CLEANUP;
            S_CLEANUP: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Output decode: next values of the registered outputs.
    always_comb begin
        w_stop_sample = (r_state == S_STOP) && w_bit_done;
`ifdef UART_RX_PARITY_EN
        w_parity_bad  = ^{r_shadow, r_parity_bit};
`else
        w_parity_bad  = 1'b0;
`endif
        w_dv_next     = w_stop_sample && w_rx_s && !w_parity_bad;
        w_ferr_next   = w_stop_sample && !w_rx_s;
        w_perr_next   = w_stop_sample && w_parity_bad;
        w_active_next = (w_state_next != S_IDLE) && (w_state_next != S_CLEANUP);
    end

    // Registered outputs; o_Rx_Byte only changes on a good frame.
    always_ff @(posedge i_Clock or posedge rst) begin
        if (rst) begin
            io_Rx.o_Rx_DV        <= 1'b0;
            io_Rx.o_Rx_Byte      <= 8'h00;
            io_Rx.o_Rx_Active    <= 1'b0;
            io_Rx.o_Rx_Frame_Err <= 1'b0;
        end else begin
            io_Rx.o_Rx_DV        <= w_dv_next;
            io_Rx.o_Rx_Active    <= w_active_next;
            io_Rx.o_Rx_Frame_Err <= w_ferr_next;
            if (w_dv_next) io_Rx.o_Rx_Byte <= r_shadow;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity error pulse, aligned with the stop-bit sample.
    always_ff @(posedge i_Clock or posedge rst) begin
        if (rst) io_Rx.o_Rx_Parity_Err <= 1'b0;
        else     io_Rx.o_Rx_Parity_Err <= w_perr_next;
    end
`else
    logic w_unused_perr;
    assign w_unused_perr = w_perr_next;
`endif

    // Baud register, bit timing counters, shadow byte and re-arm flag.
    always_ff @(posedge i_Clock or posedge rst) begin
        if (rst) begin
            r_clks_per_bit <= 32'd0;
            r_clk_count    <= 32'd0;
            r_bit_index    <= 3'd0;
            r_shadow       <= 8'h00;
            r_armed        <= 1'b1;
`ifdef UART_RX_PARITY_EN
            r_parity_bit   <= 1'b0;
`endif
        end else begin
            if (r_state == S_IDLE && io_Rx.ld_CLKS_PER_BIT)
                r_clks_per_bit <= io_Rx.CLKS_PER_BIT;

            if (w_ferr_next)  r_armed <= 1'b0;
            else if (w_rx_s)  r_armed <= 1'b1;

            case (r_state)
                S_START: begin
                    if (w_half_done) r_clk_count <= 32'd0;
                    else             r_clk_count <= r_clk_count + 32'd1;
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_shadow[r_bit_index] <= w_rx_s;
                        r_clk_count           <= 32'd0;
                        r_bit_index           <= (r_bit_index == 3'd7) ? 3'd0
                                                                       : r_bit_index + 3'd1;
                    end else begin
                        r_clk_count <= r_clk_count + 32'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_done) begin
                        r_parity_bit <= w_rx_s;
                        r_clk_count  <= 32'd0;
                    end else begin
                        r_clk_count  <= r_clk_count + 32'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_done) r_clk_count <= 32'd0;
                    else            r_clk_count <= r_clk_count + 32'd1;
                end
                default: begin
                    r_clk_count <= 32'd0;
                    r_bit_index <= 3'd0;
                end
            endcase
        end
    end

endmodule
